// File: rtl/m_dm_reader.sv
// M-stage load engine: word-aligned bus read with byte enables, lane extraction and sign/zero extension.
// Optional M_DM_TIMEOUT_EN adds a MAX_WAIT-cycle bus timeout that raises err_code 2'b10.
module m_dm_reader
`ifdef M_DM_TIMEOUT_EN
#(
    parameter int unsigned MAX_WAIT = 15
)
`endif
(
    input  logic        clk,
    input  logic        reset,
    input  logic        ld_valid,
    input  logic [31:0] ld_addr,
    input  logic [2:0]  ld_sel,
    output logic        ld_ready,
    output logic        stall,
    output logic [31:0] rd_data,
    output logic        rd_valid,
    output logic        err,
    output logic [1:0]  err_code,
    output logic        bus_req,
    output logic [31:0] bus_addr,
    output logic [3:0]  bus_byteen,
    input  logic        bus_ack,
    input  logic [31:0] bus_rdata
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_REQ  = 2'd1;
    localparam logic [1:0] S_RESP = 2'd2;

    localparam logic [2:0] SEL_LW  = 3'd0;
    localparam logic [2:0] SEL_LH  = 3'd1;
    localparam logic [2:0] SEL_LHU = 3'd2;
    localparam logic [2:0] SEL_LB  = 3'd3;
    localparam logic [2:0] SEL_LBU = 3'd4;

    localparam logic [1:0] ERR_MISALIGN = 2'b01;

`ifdef M_DM_TIMEOUT_EN
    localparam logic [1:0]  ERR_TIMEOUT = 2'b10;
    localparam int unsigned CNT_W       = $clog2(MAX_WAIT + 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
`endif

    logic [1:0]  state_q, state_d;
    logic [29:0] addr_q, addr_d;
    logic [1:0]  lane_q, lane_d;
    logic [2:0]  sel_q, sel_d;
    logic [3:0]  byteen_q, byteen_d;
    logic [31:0] rd_data_q, rd_data_d;
    logic        err_q, err_d;
    logic [1:0]  err_code_q, err_code_d;

    logic        legal;
    logic        aligned;
    logic [3:0]  req_byteen;
    logic [31:0] load_word;
    logic [7:0]  lane_byte;
    logic [15:0] lane_half;

    // Request decode: legality, alignment and byte enables from the live request.
    always_comb begin
        legal      = (ld_sel <= SEL_LBU);
        aligned    = 1'b1;
        req_byteen = 4'b0000;
        case (ld_sel)
            SEL_LW: begin
                aligned    = (ld_addr[1:0] == 2'b00);
                req_byteen = 4'b1111;
            end
            SEL_LH, SEL_LHU: begin
                aligned    = ~ld_addr[0];
                req_byteen = ld_addr[1] ? 4'b1100 : 4'b0011;
            end
            SEL_LB, SEL_LBU: begin
                req_byteen = 4'b0001 << ld_addr[1:0];
            end
            default: begin
                aligned    = 1'b1;
                req_byteen = 4'b0000;
            end
        endcase
    end

    // Lane extraction and extension using the latched address and size.
    always_comb begin
        lane_half = lane_q[1] ? bus_rdata[31:16] : bus_rdata[15:0];
        case (lane_q)
            2'd0:    lane_byte = bus_rdata[7:0];
            2'd1:    lane_byte = bus_rdata[15:8];
            2'd2:    lane_byte = bus_rdata[23:16];
            default: lane_byte = bus_rdata[31:24];
        endcase
        case (sel_q)
            SEL_LH:  load_word = {{16{lane_half[15]}}, lane_half};
            SEL_LHU: load_word = {16'h0000, lane_half};
            SEL_LB:  load_word = {{24{lane_byte[7]}}, lane_byte};
            SEL_LBU: load_word = {24'h000000, lane_byte};
            default: load_word = bus_rdata;
        endcase
    end

    // Next-state and registered-output logic.
    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        lane_d     = lane_q;
        sel_d      = sel_q;
        byteen_d   = byteen_q;
        rd_data_d  = rd_data_q;
        err_d      = 1'b0;
        err_code_d = err_code_q;
`ifdef M_DM_TIMEOUT_EN
        cnt_d      = cnt_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (ld_valid && legal) begin
                    if (aligned) begin
                        state_d  = S_REQ;
                        addr_d   = ld_addr[31:2];
                        lane_d   = ld_addr[1:0];
                        sel_d    = ld_sel;
                        byteen_d = req_byteen;
`ifdef M_DM_TIMEOUT_EN
                        cnt_d    = '0;
`endif
                    end else begin
                        err_d      = 1'b1;
                        err_code_d = ERR_MISALIGN;
                    end
                end
            end
            S_REQ: begin
                if (bus_ack) begin
                    rd_data_d = load_word;
                    state_d   = S_RESP;
`ifdef M_DM_TIMEOUT_EN
                end else if (cnt_q == CNT_W'(MAX_WAIT - 1)) begin
                    state_d    = S_IDLE;
                    err_d      = 1'b1;
                    err_code_d = ERR_TIMEOUT;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
`endif
                end
            end
            S_RESP: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            addr_q     <= '0;
            lane_q     <= '0;
            sel_q      <= '0;
            byteen_q   <= '0;
            rd_data_q  <= '0;
            err_q      <= 1'b0;
            err_code_q <= '0;
`ifdef M_DM_TIMEOUT_EN
            cnt_q      <= '0;
`endif
        end else begin
            addr_q     <= addr_d;
            lane_q     <= lane_d;
            sel_q      <= sel_d;
            byteen_q   <= byteen_d;
            rd_data_q  <= rd_data_d;
            err_q      <= err_d;
            err_code_q <= err_code_d;
`ifdef M_DM_TIMEOUT_EN
            cnt_q      <= cnt_d;
`endif
        end
    end

    // stall must cover the accept cycle, so it looks at the live request.
    assign stall      = (state_q == S_REQ) |
                        ((state_q == S_IDLE) & ld_valid & legal & aligned);
    assign ld_ready   = (state_q == S_IDLE);
    assign bus_req    = (state_q == S_REQ);
    assign rd_valid   = (state_q == S_RESP);
    assign bus_addr   = {addr_q, 2'b00};
    assign bus_byteen = byteen_q;
    assign rd_data    = rd_data_q;
    assign err        = err_q;
    assign err_code   = err_code_q;

endmodule

// File: tb/tb_m_dm_reader.sv
// Directed bench for m_dm_reader; timeout scenarios run when M_DM_TIMEOUT_EN is defined.
module tb_m_dm_reader;

    logic        clk;
    logic        reset;
    logic        ld_valid;
    logic [31:0] ld_addr;
    logic [2:0]  ld_sel;
    logic        ld_ready;
    logic        stall;
    logic [31:0] rd_data;
    logic        rd_valid;
    logic        err;
    logic [1:0]  err_code;
    logic        bus_req;
    logic [31:0] bus_addr;
    logic [3:0]  bus_byteen;
    logic        bus_ack;
    logic [31:0] bus_rdata;

    int n_cmp = 0;
    int n_mis = 0;

    m_dm_reader dut (
        .clk        (clk),
        .reset      (reset),
        .ld_valid   (ld_valid),
        .ld_addr    (ld_addr),
        .ld_sel     (ld_sel),
        .ld_ready   (ld_ready),
        .stall      (stall),
        .rd_data    (rd_data),
        .rd_valid   (rd_valid),
        .err        (err),
        .err_code   (err_code),
        .bus_req    (bus_req),
        .bus_addr   (bus_addr),
        .bus_byteen (bus_byteen),
        .bus_ack    (bus_ack),
        .bus_rdata  (bus_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset     = 1'b1;
        ld_valid  = 1'b0;
        ld_addr   = 32'h0;
        ld_sel    = 3'd7;
        bus_ack   = 1'b0;
        bus_rdata = 32'h0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        #1;
        chk("rst_ld_ready", ld_ready, 1);
        chk("rst_stall", stall, 0);
        chk("rst_bus_req", bus_req, 0);
        chk("rst_rd_valid", rd_valid, 0);
        chk("rst_rd_data", rd_data, 0);
        chk("rst_err", err, 0);
        chk("rst_err_code", err_code, 0);
        chk("rst_bus_addr", bus_addr, 0);
        chk("rst_byteen", bus_byteen, 0);

        // lb at 0x1003, ack in first REQ cycle
        next_cycle(); ld_valid = 1'b1; ld_sel = 3'd3; ld_addr = 32'h0000_1003; #1;
        chk("t1_stall_accept", stall, 1);
        chk("t1_ready_accept", ld_ready, 1);
        next_cycle(); ld_valid = 1'b0; ld_sel = 3'd7; bus_ack = 1'b1; bus_rdata = 32'h80FF_1234; #1;
        chk("t1_bus_req", bus_req, 1);
        chk("t1_bus_addr", bus_addr, 32'h0000_1000);
        chk("t1_byteen", bus_byteen, 4'b1000);
        chk("t1_stall_req", stall, 1);
        chk("t1_ready_req", ld_ready, 0);
        chk("t1_no_early_valid", rd_valid, 0);
        next_cycle(); bus_ack = 1'b0; #1;
        chk("t1_rd_valid", rd_valid, 1);
        chk("t1_rd_data", rd_data, 32'hFFFF_FF80);
        chk("t1_stall_resp", stall, 0);
        chk("t1_req_drop", bus_req, 0);
        next_cycle(); #1;
        chk("t1_valid_pulse", rd_valid, 0);
        chk("t1_ready_back", ld_ready, 1);
        chk("t1_rd_data_hold", rd_data, 32'hFFFF_FF80);

        // lhu at 0x2002, ack in third REQ cycle
        next_cycle(); ld_valid = 1'b1; ld_sel = 3'd2; ld_addr = 32'h0000_2002; #1;
        chk("t2_stall_T", stall, 1);
        for (int i = 1; i <= 3; i++) begin
            next_cycle(); ld_valid = 1'b0; ld_sel = 3'd7;
            if (i == 3) begin
                bus_ack = 1'b1; bus_rdata = 32'h8001_7FFF;
            end
            #1;
            chk("t2_bus_req", bus_req, 1);
            chk("t2_stall_wait", stall, 1);
            if (i == 1) chk("t2_byteen", bus_byteen, 4'b1100);
        end
        next_cycle(); bus_ack = 1'b0; #1;
        chk("t2_rd_valid", rd_valid, 1);
        chk("t2_rd_data", rd_data, 32'h0000_8001);
        chk("t2_stall_resp", stall, 0);

        // misaligned lw at 0x6
        next_cycle(); ld_valid = 1'b1; ld_sel = 3'd0; ld_addr = 32'h0000_0006; #1;
        chk("t3_stall", stall, 0);
        chk("t3_ready", ld_ready, 1);
        next_cycle(); ld_valid = 1'b0; ld_sel = 3'd7; #1;
        chk("t3_err", err, 1);
        chk("t3_err_code", err_code, 2'b01);
        chk("t3_no_bus_req", bus_req, 0);
        chk("t3_ready_after", ld_ready, 1);
        chk("t3_no_rd_valid", rd_valid, 0);
        next_cycle(); #1;
        chk("t3_err_pulse", err, 0);
        chk("t3_err_code_hold", err_code, 2'b01);

        // ld_sel=7 is not a load
        next_cycle(); ld_valid = 1'b1; ld_sel = 3'd7; ld_addr = 32'h0000_0000; #1;
        chk("t6_stall", stall, 0);
        next_cycle(); #1;
        chk("t6_bus_req", bus_req, 0);
        chk("t6_err", err, 0);
        chk("t6_rd_data", rd_data, 32'h0000_8001);
        chk("t6_ready", ld_ready, 1);
        chk("t6_stall2", stall, 0);
        ld_valid = 1'b0;

        // lh at 0x4 aborted by reset in the second REQ cycle
        next_cycle(); ld_valid = 1'b1; ld_sel = 3'd1; ld_addr = 32'h0000_0004; #1;
        chk("t5_stall_accept", stall, 1);
        next_cycle(); ld_valid = 1'b0; ld_sel = 3'd7; #1;
        chk("t5_bus_req1", bus_req, 1);
        chk("t5_byteen", bus_byteen, 4'b0011);
        next_cycle(); #1;
        chk("t5_bus_req2", bus_req, 1);
        reset = 1'b1; bus_ack = 1'b1; bus_rdata = 32'h0000_F00D; #1;
        chk("t5_async_req_drop", bus_req, 0);
        chk("t5_async_ready", ld_ready, 1);
        chk("t5_async_rd_data", rd_data, 0);
        chk("t5_async_bus_addr", bus_addr, 0);
        chk("t5_async_byteen", bus_byteen, 0);
        chk("t5_async_err_code", err_code, 0);
        next_cycle(); reset = 1'b0; bus_ack = 1'b0; #1;
        next_cycle(); #1;
        chk("t5_no_rd_valid", rd_valid, 0);
        chk("t5_no_err", err, 0);
        chk("t5_ready_idle", ld_ready, 1);
        ld_valid = 1'b1; ld_sel = 3'd4; ld_addr = 32'h0000_0005; #1;
        chk("t5_lbu_stall", stall, 1);
        next_cycle(); ld_valid = 1'b0; ld_sel = 3'd7; bus_ack = 1'b1; bus_rdata = 32'h0000_AB00; #1;
        chk("t5_lbu_req", bus_req, 1);
        chk("t5_lbu_byteen", bus_byteen, 4'b0010);
        chk("t5_lbu_addr", bus_addr, 32'h0000_0004);
        next_cycle(); bus_ack = 1'b0; #1;
        chk("t5_lbu_valid", rd_valid, 1);
        chk("t5_lbu_data", rd_data, 32'h0000_00AB);

`ifdef M_DM_TIMEOUT_EN
        // no ack: 15 REQ cycles then timeout
        next_cycle(); ld_valid = 1'b1; ld_sel = 3'd0; ld_addr = 32'h0000_0100; #1;
        for (int i = 1; i <= 15; i++) begin
            next_cycle(); ld_valid = 1'b0; ld_sel = 3'd7; #1;
            chk("t4_req_held", bus_req, 1);
        end
        next_cycle(); #1;
        chk("t4_req_drop", bus_req, 0);
        chk("t4_err", err, 1);
        chk("t4_err_code", err_code, 2'b10);
        chk("t4_no_rd_valid", rd_valid, 0);
        chk("t4_ready", ld_ready, 1);
        next_cycle(); #1;
        chk("t4_err_pulse", err, 0);
        chk("t4_no_rd_valid2", rd_valid, 0);

        // ack on the 15th REQ cycle wins over the timeout
        ld_valid = 1'b1; ld_sel = 3'd0; ld_addr = 32'h0000_0100; #1;
        for (int i = 1; i <= 15; i++) begin
            next_cycle(); ld_valid = 1'b0; ld_sel = 3'd7;
            if (i == 15) begin
                bus_ack = 1'b1; bus_rdata = 32'h1234_5678;
            end
            #1;
            chk("t4b_req_held", bus_req, 1);
        end
        next_cycle(); bus_ack = 1'b0; #1;
        chk("t4b_rd_valid", rd_valid, 1);
        chk("t4b_no_err", err, 0);
        chk("t4b_rd_data", rd_data, 32'h1234_5678);
`endif

        next_cycle();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
